// File: rtl/fase2_multiciclo.sv
// fase2_multiciclo: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB).
// Optional jump opcode enabled by defining FASE2_JUMP_EN.
module fase2_multiciclo #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NREG     = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic          inclk,
    input  logic          inrst_n,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_data,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_we,
    output logic          dmem_re,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic [31:0]   pc,
    output logic [2:0]    estado,
    output logic          halt
);

    localparam int unsigned AW = $clog2(NREG);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;
`ifdef FASE2_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [2:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] rf_q [NREG];

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [AW-1:0] rs_idx;
    logic [AW-1:0] rt_idx;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [31:0]   br_off;

    logic          is_r;
    logic          is_lw;
    logic          is_sw;
    logic          is_beq;
    logic          is_addi;
    logic          is_halt;
    logic          is_j;

    logic [DW-1:0] alu_res;
    logic          r_ok;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: AW];
    assign rt_idx = ir_q[16 +: AW];
    assign rd_idx = ir_q[11 +: AW];

    // Branch offset: word displacement scaled to bytes, relative to pc+4
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    assign is_r    = (opcode == OP_RTYPE);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_addi = (opcode == OP_ADDI);
    assign is_halt = (opcode == OP_HALT);
`ifdef FASE2_JUMP_EN
    assign is_j    = (opcode == OP_J);
`else
    assign is_j    = 1'b0;
`endif

    // Register 0 is hard-wired to zero on the read side
    assign rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];

    // ALU: R-type ops on A/B, otherwise A + sign-extended immediate
    always_comb begin
        alu_res = a_q + imm_q;
        r_ok    = 1'b1;
        if (is_r) begin
            case (funct)
                FN_ADD:  alu_res = a_q + b_q;
                FN_SUB:  alu_res = a_q - b_q;
                FN_AND:  alu_res = a_q & b_q;
                FN_OR:   alu_res = a_q | b_q;
                FN_SLT:  alu_res = {{(DW-1){1'b0}},
                                    ($signed(a_q) < $signed(b_q))};
                default: r_ok = 1'b0;
            endcase
        end
    end

    // Control FSM and next values of all architectural registers
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        case (state_q)
            S_FETCH: begin
                ir_d    = imem_data;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                imm_d   = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (1'b1)
                    is_r: begin
                        if (r_ok) begin
                            alu_d   = alu_res;
                            state_d = S_WB;
                        end
                    end
                    is_addi: begin
                        alu_d   = alu_res;
                        state_d = S_WB;
                    end
                    is_lw, is_sw: begin
                        alu_d   = alu_res;
                        state_d = S_MEM;
                    end
                    is_beq: begin
                        if (a_q == b_q) begin
                            pc_d = pc_q + br_off;
                        end
                    end
                    is_j: begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    end
                    is_halt: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_lw) begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
                if (is_r) begin
                    rf_wa = rd_idx;
                    rf_wd = alu_q;
                end else if (is_addi) begin
                    rf_wa = rt_idx;
                    rf_wd = alu_q;
                end else begin
                    rf_wa = rt_idx;
                    rf_wd = mdr_q;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file; writes to register 0 are dropped
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rf_wa != '0)) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign estado     = state_q;
    assign halt       = (state_q == S_HALT);
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign dmem_re    = (state_q == S_MEM) && is_lw;
    assign dmem_we    = (state_q == S_MEM) && is_sw;

endmodule

// File: tb/tb_fase2_multiciclo.sv
// tb_fase2_multiciclo: directed program run with a store scoreboard.
// Build with FASE2_JUMP_EN defined to exercise the jump path.
module tb_fase2_multiciclo;

    localparam int DW = 32;

`ifdef FASE2_JUMP_EN
    localparam logic [31:0] JT = 32'h0000_0100;
`else
    localparam logic [31:0] JT = 32'h0000_006C;
`endif

    logic          inclk = 1'b0;
    logic          inrst_n = 1'b0;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_we;
    logic          dmem_re;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ready = 1'b1;
    logic [31:0]   pc;
    logic [2:0]    estado;
    logic          halt;

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:63];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;
    st_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pc_hold;

    fase2_multiciclo dut (
        .inclk      (inclk),
        .inrst_n    (inrst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc         (pc),
        .estado     (estado),
        .halt       (halt)
    );

    always #5 inclk = ~inclk;

    assign imem_data  = imem[imem_addr[8:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge inclk) begin
        if (inrst_n && dmem_we && dmem_ready) begin
            dmem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge inclk);
            #1;
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic st_t st(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a;
        s.data = d;
        return s;
    endfunction

    // Store monitor: every completed store must match the next expectation
    always @(negedge inclk) begin
        if (inrst_n && (dmem_we || dmem_re)) begin
            chk("strobe_excl", {63'd0, dmem_we & dmem_re}, 64'd0);
        end
        if (inrst_n && dmem_we && dmem_ready) begin
            chk("sb_avail", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
                st_t e;
                e = sb.pop_front();
                chk("st_addr", {32'd0, dmem_addr}, {32'd0, e.addr});
                chk("st_data", {32'd0, dmem_wdata}, {32'd0, e.data});
            end
        end
    end

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] SLT = 6'b101010;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
        dmem[16] = 32'h7FFF_FFFF;

        imem[0]  = i_ins(ADI, 0, 1, 16'd5);
        imem[1]  = i_ins(ADI, 0, 2, 16'hFFFD);
        imem[2]  = r_ins(1, 2, 3, ADD);
        imem[3]  = i_ins(SW, 0, 3, 16'd4);
        imem[4]  = i_ins(BEQ, 1, 1, 16'hFFFF);
        imem[5]  = i_ins(SW, 0, 1, 16'd8);
        imem[6]  = i_ins(LW, 0, 4, 16'd8);
        imem[7]  = i_ins(SW, 0, 4, 16'd12);
        imem[8]  = i_ins(ADI, 0, 0, 16'd7);
        imem[9]  = r_ins(2, 1, 5, SLT);
        imem[10] = i_ins(SW, 0, 0, 16'd16);
        imem[11] = i_ins(SW, 0, 5, 16'd20);
        imem[12] = i_ins(LW, 0, 6, 16'd64);
        imem[13] = i_ins(ADI, 0, 7, 16'd1);
        imem[14] = r_ins(6, 7, 8, ADD);
        imem[15] = i_ins(SW, 0, 8, 16'd24);
        imem[16] = r_ins(2, 1, 9, SUB);
        imem[17] = i_ins(SW, 0, 9, 16'd28);
        imem[18] = r_ins(1, 2, 10, AND);
        imem[19] = i_ins(SW, 0, 10, 16'd32);
        imem[20] = r_ins(1, 2, 11, OR);
        imem[21] = i_ins(SW, 0, 11, 16'd36);
        imem[22] = r_ins(1, 2, 12, SLT);
        imem[23] = i_ins(SW, 0, 12, 16'd40);
        imem[24] = r_ins(0, 0, 1, 6'b000000);
        imem[25] = i_ins(SW, 0, 1, 16'd44);
        imem[26] = {6'b000010, 26'h40};
        imem[27] = {6'b111111, 26'd0};
        imem[64] = {6'b111111, 26'd0};

        // Reset
        ticks(2);
        chk("rst_estado", {61'd0, estado}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'd0);
        chk("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
        chk("rst_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_re", {63'd0, dmem_re}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        inrst_n = 1'b1;

        // addi, addi, add: 12 cycles
        ticks(1);
        chk("fetch_estado", {61'd0, estado}, 64'd1);
        chk("fetch_pc", {32'd0, pc}, 64'd4);
        ticks(11);
        chk("alu3_pc", {32'd0, pc}, 64'd12);
        chk("alu3_estado", {61'd0, estado}, 64'd0);

        // sw r3 -> checks r3 = 2
        sb.push_back(st(32'd4, 32'd2));
        ticks(4);
        chk("sw_r3_pc", {32'd0, pc}, 64'h10);

        // beq taken back to itself
        ticks(1);
        chk("beq_pc_mid", {32'd0, pc}, 64'h14);
        ticks(2);
        chk("beq_taken_pc", {32'd0, pc}, 64'h10);
        chk("beq_taken_st", {61'd0, estado}, 64'd0);
        imem[4] = i_ins(BEQ, 1, 2, 16'd5);
        ticks(3);
        chk("beq_nt_pc", {32'd0, pc}, 64'h14);

        // sw with three wait cycles
        dmem_ready = 1'b0;
        sb.push_back(st(32'd8, 32'd5));
        ticks(3);
        chk("sw_mem_st", {61'd0, estado}, 64'd3);
        chk("sw_we_1", {63'd0, dmem_we}, 64'd1);
        chk("sw_re", {63'd0, dmem_re}, 64'd0);
        chk("sw_addr", {32'd0, dmem_addr}, 64'd8);
        chk("sw_wdata", {32'd0, dmem_wdata}, 64'd5);
        ticks(1);
        chk("sw_we_2", {63'd0, dmem_we}, 64'd1);
        ticks(1);
        chk("sw_we_3", {63'd0, dmem_we}, 64'd1);
        ticks(1);
        chk("sw_we_4", {63'd0, dmem_we}, 64'd1);
        dmem_ready = 1'b1;
        ticks(1);
        chk("sw_we_off", {63'd0, dmem_we}, 64'd0);
        chk("sw_done_st", {61'd0, estado}, 64'd0);
        chk("sw_done_pc", {32'd0, pc}, 64'h18);

        // lw r4: 5 cycles
        ticks(3);
        chk("lw_re", {63'd0, dmem_re}, 64'd1);
        chk("lw_we", {63'd0, dmem_we}, 64'd0);
        chk("lw_addr", {32'd0, dmem_addr}, 64'd8);
        ticks(1);
        chk("lw_wb_st", {61'd0, estado}, 64'd4);
        ticks(1);
        chk("lw_done_pc", {32'd0, pc}, 64'h1C);

        // r4, r0, slt, overflow add, sub/and/or/slt results via stores
        sb.push_back(st(32'd12, 32'd5));
        sb.push_back(st(32'd16, 32'd0));
        sb.push_back(st(32'd20, 32'd1));
        sb.push_back(st(32'd24, 32'h8000_0000));
        sb.push_back(st(32'd28, 32'hFFFF_FFF8));
        sb.push_back(st(32'd32, 32'd5));
        sb.push_back(st(32'd36, 32'hFFFF_FFFD));
        sb.push_back(st(32'd40, 32'd0));
        ticks(69);
        chk("seq_pc", {32'd0, pc}, 64'h60);
        chk("seq_estado", {61'd0, estado}, 64'd0);

        // unknown funct is a 3-cycle NOP
        ticks(3);
        chk("nop_pc", {32'd0, pc}, 64'h64);
        chk("nop_estado", {61'd0, estado}, 64'd0);
        sb.push_back(st(32'd44, 32'd5));
        ticks(4);
        chk("nop_sw_pc", {32'd0, pc}, 64'h68);

        // jump (or NOP)
        ticks(3);
        chk("j_pc", {32'd0, pc}, {32'd0, JT});

        // halt
        ticks(3);
        chk("halt_flag", {63'd0, halt}, 64'd1);
        chk("halt_estado", {61'd0, estado}, 64'd7);
        pc_hold = JT + 32'd4;
        chk("halt_pc", {32'd0, pc}, {32'd0, pc_hold});
        ticks(20);
        chk("halt_pc_20", {32'd0, pc}, {32'd0, pc_hold});
        chk("halt_estado_20", {61'd0, estado}, 64'd7);
        inrst_n = 1'b0;
        ticks(1);
        chk("hrst_estado", {61'd0, estado}, 64'd0);
        chk("hrst_pc", {32'd0, pc}, 64'd0);
        chk("hrst_halt", {63'd0, halt}, 64'd0);

        // reset during a stalled store abandons it
        imem[0] = i_ins(SW, 0, 0, 16'd48);
        dmem_ready = 1'b0;
        inrst_n = 1'b1;
        ticks(3);
        chk("mrst_pre_st", {61'd0, estado}, 64'd3);
        chk("mrst_pre_we", {63'd0, dmem_we}, 64'd1);
        inrst_n = 1'b0;
        ticks(1);
        chk("mrst_we", {63'd0, dmem_we}, 64'd0);
        chk("mrst_estado", {61'd0, estado}, 64'd0);
        chk("mrst_pc", {32'd0, pc}, 64'd0);
        inrst_n = 1'b1;
        dmem_ready = 1'b1;

        chk("sb_drained", {32'd0, sb.size()}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
